// File: rtl/seq_scan_ctrl.sv
// Word scanner: shifts a captured word out MSB first through a 1011 Mealy
// detector and reports match count, presence and position of the first match.
module seq_scan_ctrl #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [WORD_W-1:0]         word,
  input  logic                      overlap,
  output logic                      busy,
  output logic                      done,
  output logic                      ser_bit,
  output logic                      hit,
  output logic [1:0]                det_state,
  output logic [CNT_W-1:0]          match_cnt,
  output logic                      found,
  output logic [$clog2(WORD_W)-1:0] first_pos
);

  localparam int IDX_W = $clog2(WORD_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {S0 = 2'b00, S1 = 2'b01, S2 = 2'b10, S3 = 2'b11} det_t;

  state_t            state;
  det_t              det_q;
  det_t              det_nxt;
  logic [WORD_W-1:0] shreg;
  logic              ovl_q;
  logic [IDX_W-1:0]  idx;

  // The captured word is consumed by shifting, so its MSB is always the current bit.
  assign ser_bit   = busy & shreg[WORD_W-1];
  assign hit       = busy && (det_q == S3) && ser_bit;
  assign det_state = det_q;

  always_comb begin
    det_nxt = det_q;
    case (det_q)
      S0: det_nxt = ser_bit ? S1 : S0;
      S1: det_nxt = ser_bit ? S1 : S2;
      S2: det_nxt = ser_bit ? S3 : S0;
      S3: det_nxt = ser_bit ? (ovl_q ? S1 : S0) : S2;
      default: det_nxt = S0;
    endcase
  end

  // Controller, detector and result registers share one sequential block;
  // busy/done are registered alongside the state so they change with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      det_q     <= S0;
      shreg     <= '0;
      ovl_q     <= 1'b0;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      match_cnt <= '0;
      found     <= 1'b0;
      first_pos <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shreg     <= word;
            ovl_q     <= overlap;
            match_cnt <= '0;
            found     <= 1'b0;
            first_pos <= '0;
            det_q     <= S0;
            idx       <= '0;
            busy      <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          det_q <= det_nxt;
          shreg <= {shreg[WORD_W-2:0], 1'b0};
          idx   <= idx + 1'b1;
          if (hit) begin
            if (match_cnt != '1)
              match_cnt <= match_cnt + 1'b1;
            if (!found) begin
              found     <= 1'b1;
              first_pos <= idx;
            end
          end
          if (idx == LAST_IDX) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
